req_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 24 ++
 rtl/arb_prio_enc.sv | 24 ++
 rtl/req_arbiter.sv | 131 +++++++++++++
 tb/tb_req_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester arbiter.
package arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned ID_W  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      GAP   = 2'b10
   } arb_state_t;

   // casez patterns for the fixed-priority encoder, bit 3 highest
   localparam logic [N_REQ-1:0] PAT_ID3 = 4'b1???;
   localparam logic [N_REQ-1:0] PAT_ID2 = 4'b01??;
   localparam logic [N_REQ-1:0] PAT_ID1 = 4'b001?;
   localparam logic [N_REQ-1:0] PAT_ID0 = 4'b0001;

   function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
      id2onehot     = '0;
      id2onehot[id] = 1'b1;
   endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Four-input fixed-priority encoder, bit 3 wins. Anything not matching a
// definite pattern (including unknown inputs) reports no hit.
module arb_prio_enc
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   output logic             hit,
   output logic [ID_W-1:0]  id
);

   // priority decode of the request vector
   always_comb begin
      hit = 1'b0;
      id  = '0;
      casez (req)
         PAT_ID3: begin hit = 1'b1; id = 2'd3; end
         PAT_ID2: begin hit = 1'b1; id = 2'd2; end
         PAT_ID1: begin hit = 1'b1; id = 2'd1; end
         PAT_ID0: begin hit = 1'b1; id = 2'd0; end
         default: begin hit = 1'b0; id = '0;   end
      endcase
   end

endmodule

// File: rtl/req_arbiter.sv
// Four-requester arbiter: registered one-hot grant held until the owner
// releases or the hold timeout fires, followed by a one-cycle gap.
// Optional macro ARB_ROUND_ROBIN_EN selects rotating priority starting
// after the last winner; otherwise fixed priority with req[3] highest.
module req_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_vld,
   output logic             timeout
);

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   arb_state_t       state;
   logic [CNT_W-1:0] hold_cnt;
   logic [N_REQ-1:0] mask;
   logic [ID_W-1:0]  last_id;

   logic [N_REQ-1:0] avail;
   logic [ID_W-1:0]  off;
   logic [N_REQ-1:0] rot;
   logic [N_REQ-1:0] enc_in;
   logic             enc_hit;
   logic [ID_W-1:0]  enc_id;
   logic [ID_W-1:0]  win_id;

   // Round-robin reuses the bit3-first encoder: rotate right so the
   // preferred requester lands in bit 0, bit-reverse, then map the index
   // back (~id undoes the reversal, +off undoes the rotation).
   always_comb begin
      avail  = req & ~mask;
      off    = RR_EN ? ID_W'(last_id + 1'b1) : '0;
      rot    = '0;
      enc_in = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         rot[i] = avail[ID_W'(i) + off];
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         enc_in[i] = RR_EN ? rot[N_REQ-1-i] : rot[i];
      end
   end

   arb_prio_enc u_enc (
      .req (enc_in),
      .hit (enc_hit),
      .id  (enc_id)
   );

   // map encoder index back to a requester id
   always_comb begin
      win_id = RR_EN ? ID_W'(~enc_id + off) : enc_id;
   end

   // arbitration FSM with registered grant, counter, mask and timeout
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         gnt_vld  <= 1'b0;
         timeout  <= 1'b0;
         hold_cnt <= '0;
         mask     <= '0;
         last_id  <= 2'd3;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (enc_hit) begin
                  gnt      <= id2onehot(win_id);
                  gnt_id   <= win_id;
                  gnt_vld  <= 1'b1;
                  hold_cnt <= CNT_W'(1);
                  last_id  <= win_id;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (!req[gnt_id]) begin
                  gnt     <= '0;
                  gnt_vld <= 1'b0;
                  state   <= GAP;
               end else if ((MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD))) begin
                  gnt     <= '0;
                  gnt_vld <= 1'b0;
                  timeout <= 1'b1;
                  mask    <= id2onehot(gnt_id);
                  state   <= GAP;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            GAP: begin
               mask <= '0;
               if (enc_hit) begin
                  gnt      <= id2onehot(win_id);
                  gnt_id   <= win_id;
                  gnt_vld  <= 1'b1;
                  hold_cnt <= CNT_W'(1);
                  last_id  <= win_id;
                  state    <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               gnt      <= '0;
               gnt_id   <= '0;
               gnt_vld  <= 1'b0;
               timeout  <= 1'b0;
               hold_cnt <= '0;
               mask     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter: two instances (hold limits 16 and 4)
// share one stimulus stream and are compared every cycle against a
// behavioural ownership model, plus directed literal expectations.
module tb_req_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = '0;

   logic [3:0] gnt_a, gnt_b;
   logic [1:0] gnt_id_a, gnt_id_b;
   logic       gnt_vld_a, gnt_vld_b;
   logic       timeout_a, timeout_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   req_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt_a), .gnt_id(gnt_id_a), .gnt_vld(gnt_vld_a), .timeout(timeout_a)
   );

   req_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt_b), .gnt_id(gnt_id_b), .gnt_vld(gnt_vld_b), .timeout(timeout_b)
   );

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int owner;    // -1 when nobody holds the resource
      int held;     // cycles the current owner has been visible
      bit gap;      // this cycle is the turnaround after a release
      int blocked;  // requester barred from the next pick after a timeout
      int last;     // most recent winner
      bit tmo;
   } mdl_t;

   mdl_t ma, mb;
   bit   mdl_ok = 1'b0;

   function automatic int pick(input logic [3:0] r, input int last);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = RR ? (last + 1 + k) % 4 : 3 - k;
         if (r[i] === 1'b1) return i;
      end
      return -1;
   endfunction

   function automatic mdl_t step(input mdl_t s, input logic [3:0] r, input logic rn, input int mh);
      mdl_t n;
      logic [3:0] av;
      int w;
      n     = s;
      n.tmo = 1'b0;
      if (rn !== 1'b1) begin
         n.owner = -1; n.held = 0; n.gap = 1'b0; n.blocked = -1; n.last = 3;
         return n;
      end
      if (s.owner >= 0) begin
         if (r[s.owner] !== 1'b1) begin
            n.owner = -1; n.gap = 1'b1;
         end else if (mh != 0 && s.held == mh) begin
            n.owner = -1; n.gap = 1'b1; n.tmo = 1'b1; n.blocked = s.owner;
         end else begin
            n.held = (s.held < 31) ? s.held + 1 : 31;
         end
      end else begin
         av = r;
         if (s.blocked >= 0) av[s.blocked] = 1'b0;
         w = pick(av, s.last);
         n.blocked = -1;
         n.gap     = 1'b0;
         if (w >= 0) begin
            n.owner = w; n.held = 1; n.last = w;
         end
      end
      return n;
   endfunction

   function automatic logic [3:0] exp_gnt(input mdl_t s);
      return (s.owner >= 0) ? 4'(4'b0001 << s.owner) : 4'b0000;
   endfunction

   // advance the model on every rising edge
   always @(posedge clk) begin
      ma <= step(ma, req, rst_n, 16);
      mb <= step(mb, req, rst_n, 4);
      if (rst_n === 1'b0) mdl_ok <= 1'b1;
   end

   // compare both DUTs against the model away from the active edge
   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("a.gnt", gnt_a, exp_gnt(ma));
         chk("a.vld", 4'(gnt_vld_a), 4'(ma.owner >= 0));
         chk("a.timeout", 4'(timeout_a), 4'(ma.tmo));
         if (ma.owner >= 0) chk("a.gnt_id", 4'(gnt_id_a), 4'(ma.owner));
         chk("b.gnt", gnt_b, exp_gnt(mb));
         chk("b.vld", 4'(gnt_vld_b), 4'(mb.owner >= 0));
         chk("b.timeout", 4'(timeout_b), 4'(mb.tmo));
         if (mb.owner >= 0) chk("b.gnt_id", 4'(gnt_id_b), 4'(mb.owner));
      end
   end

   // ---------------- stimulus ----------------
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // two reset cycles, then release reset with r applied (cycle 0)
   task automatic start(input logic [3:0] r);
      rst_n = 1'b0;
      next();
      next();
      rst_n = 1'b1;
      req   = r;
   endtask

   int order[$];
   int exp_order[5];
   int run;
   logic [3:0] prev_gnt;

   initial begin
      // reset held with all requests asserted
      #1;
      rst_n = 1'b0;
      req   = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         next();
         chk("rst.gnt", gnt_a, 4'b0000);
         chk("rst.vld", 4'(gnt_vld_a), 4'd0);
         chk("rst.timeout", 4'(timeout_a), 4'd0);
      end
      rst_n = 1'b1;
      next();
      chk("rst.first_gnt", gnt_a, RR ? 4'b0001 : 4'b1000);

      // basic hold and release
      start(4'b0110);
      next();
`ifdef ARB_ROUND_ROBIN_EN
      chk("basic.gnt_c1", gnt_a, 4'b0010);
      chk("basic.id_c1", 4'(gnt_id_a), 4'd1);
`else
      chk("basic.gnt_c1", gnt_a, 4'b0100);
      chk("basic.id_c1", 4'(gnt_id_a), 4'd2);
      next(); next(); next();
      next();
      req = 4'b0010;
      chk("basic.gnt_c5", gnt_a, 4'b0100);
      next();
      chk("basic.gap_c6", gnt_a, 4'b0000);
      next();
      chk("basic.gnt_c7", gnt_a, 4'b0010);
      chk("basic.id_c7", 4'(gnt_id_a), 4'd1);
`endif

      // hold timeout on the MAX_HOLD=4 instance
      start(4'b1000);
      for (int k = 1; k <= 4; k++) begin
         next();
         chk("tmo.gnt_hold", gnt_b, 4'b1000);
         chk("tmo.no_pulse", 4'(timeout_b), 4'd0);
      end
      next();
      chk("tmo.gnt_c5", gnt_b, 4'b0000);
      chk("tmo.pulse_c5", 4'(timeout_b), 4'd1);
      chk("tmo.long_hold_c5", gnt_a, 4'b1000);
      next();
      chk("tmo.gnt_c6", gnt_b, 4'b0000);
      chk("tmo.pulse_c6", 4'(timeout_b), 4'd0);
      next();
      chk("tmo.regrant_c7", gnt_b, 4'b1000);

      // ordering with every owner releasing after two cycles
      start(4'b1111);
      run      = 0;
      prev_gnt = '0;
      for (int c = 0; c < 60 && order.size() < 5; c++) begin
         next();
         if (gnt_vld_a) begin
            if (gnt_a != prev_gnt) begin
               order.push_back(int'(gnt_id_a));
               run = 1;
            end else begin
               run++;
            end
         end else begin
            run = 0;
         end
         prev_gnt = gnt_vld_a ? gnt_a : 4'b0000;
         req = 4'b1111;
         if (gnt_vld_a && run == 2) req[gnt_id_a] = 1'b0;
      end
      exp_order = RR ? '{0, 1, 2, 3, 0} : '{3, 3, 3, 3, 3};
      checks++;
      if (order.size() < 5) begin
         errors++;
         $display("FAIL order.count: got %0d grants expected 5 within budget", order.size());
      end else begin
         for (int i = 0; i < 5; i++) chk("order.id", 4'(order[i]), 4'(exp_order[i]));
      end

      // reset while a grant is held
      start(4'b0010);
      next();
      chk("midrst.gnt_c1", gnt_a, 4'b0010);
      next();
      next();
      rst_n = 1'b0;
      next();
      chk("midrst.gnt_c4", gnt_a, 4'b0000);
      chk("midrst.vld_c4", 4'(gnt_vld_a), 4'd0);
      rst_n = 1'b1;
      req   = 4'b0010;
      next();
      chk("midrst.regrant", gnt_a, 4'b0010);
      chk("midrst.id", 4'(gnt_id_a), 4'd1);

      // unknown request bits: no definite 1 and no z, so casez can only
      // fall through to its default branch
      start(4'b0xx0);
      for (int k = 0; k < 4; k++) begin
         next();
         chk("illegal.vld_a", 4'(gnt_vld_a), 4'd0);
         chk("illegal.vld_b", 4'(gnt_vld_b), 4'd0);
      end

      // randomized traffic with occasional resets
      start(4'b0000);
      for (int c = 0; c < 3000; c++) begin
         next();
         rst_n = ($urandom_range(63) != 0);
         if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
      end

      next();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
